// File: rtl/sonuc_bcd_donusturucu_pkg.sv
// Shared constants and state encoding for the product-to-BCD converter.
package hesap_paket;

  localparam int SONUC_GENISLIK = 64;
  localparam int BCD_BASAMAK    = 19;
  localparam int SAYAC_GENISLIK = 6;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    MUTLAK = 2'd1,
    KAYDIR = 2'd2,
    BITTI  = 2'd3
  } durum_t;

endpackage

// File: rtl/sonuc_bcd_donusturucu_duzelt.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_basamak_duzelt (
  input  logic [3:0] basamak_i,
  output logic [3:0] duzeltilmis_o
);

  assign duzeltilmis_o = (basamak_i >= 4'd5) ? basamak_i + 4'd3 : basamak_i;

endmodule

// File: rtl/sonuc_bcd_donusturucu.sv
// Sequential signed-binary to sign + packed-BCD converter, one operand bit per clock.
module sonuc_bcd_donusturucu
  import hesap_paket::*;
#(
  parameter int GENISLIK = SONUC_GENISLIK,
  parameter int BASAMAK  = BCD_BASAMAK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GENISLIK-1:0]    giris,
  input  logic                   giris_gecerli,
  output logic                   hazir,
  output logic [4*BASAMAK-1:0]   bcd_cikis,
  output logic                   isaret,
  output logic [4:0]             basamak_sayisi,
  output logic                   cikis_gecerli,
  output logic                   mesgul
);

  localparam int BW = 4 * BASAMAK;
  localparam logic [SAYAC_GENISLIK-1:0] SON_SAYAC = SAYAC_GENISLIK'(GENISLIK - 1);

  durum_t                    durum_q, durum_d;
  logic [GENISLIK-1:0]       islenen_q, islenen_d;
  logic [BW-1:0]             karalama_q, karalama_d;
  logic [BW-1:0]             duzeltilmis;
  logic [SAYAC_GENISLIK-1:0] sayac_q, sayac_d;
  logic                      isaret_ic_q, isaret_ic_d;
  logic [BW-1:0]             bcd_q, bcd_d;
  logic                      isaret_q, isaret_d;
  logic [4:0]                basamak_q, basamak_d;
  logic                      gecerli_q, gecerli_d;
  logic [4:0]                basamak_hesap;

  for (genvar i = 0; i < BASAMAK; i++) begin : g_basamak
    bcd_basamak_duzelt u_duzelt (
      .basamak_i     (karalama_q[4*i +: 4]),
      .duzeltilmis_o (duzeltilmis[4*i +: 4])
    );

    // Shift-after-correction must never leave a non-decimal digit behind.
    a_basamak_gecerli : assert property (
      @(posedge clk) disable iff (rst) karalama_q[4*i +: 4] <= 4'd9
    );
  end

  always_comb begin
    basamak_hesap = 5'd1;
    for (int i = 0; i < BASAMAK; i++) begin
      if (karalama_q[4*i +: 4] != 4'd0) basamak_hesap = 5'(i + 1);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    durum_d     = durum_q;
    islenen_d   = islenen_q;
    karalama_d  = karalama_q;
    sayac_d     = sayac_q;
    isaret_ic_d = isaret_ic_q;
    bcd_d       = bcd_q;
    isaret_d    = isaret_q;
    basamak_d   = basamak_q;
    gecerli_d   = 1'b0;

    unique case (durum_q)
      BOSTA: begin
        if (giris_gecerli) begin
          islenen_d = giris;
          durum_d   = MUTLAK;
        end
      end
      MUTLAK: begin
        // Magnitude is kept unsigned, so the most negative input maps to 2^(W-1) cleanly.
        isaret_ic_d = islenen_q[GENISLIK-1];
        if (islenen_q[GENISLIK-1]) islenen_d = -islenen_q;
        karalama_d = '0;
        sayac_d    = '0;
        durum_d    = KAYDIR;
      end
      KAYDIR: begin
        karalama_d = {duzeltilmis[BW-2:0], islenen_q[GENISLIK-1]};
        islenen_d  = islenen_q << 1;
        sayac_d    = sayac_q + 1'b1;
        if (sayac_q == SON_SAYAC) durum_d = BITTI;
      end
      BITTI: begin
        bcd_d     = karalama_q;
        isaret_d  = isaret_ic_q;
        basamak_d = basamak_hesap;
        gecerli_d = 1'b1;
        durum_d   = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  // NOTE: the scratch and operand are plain registers, so they are reset along with the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q     <= BOSTA;
      islenen_q   <= '0;
      karalama_q  <= '0;
      sayac_q     <= '0;
      isaret_ic_q <= 1'b0;
      bcd_q       <= '0;
      isaret_q    <= 1'b0;
      basamak_q   <= 5'd1;
      gecerli_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      durum_q     <= durum_d;
      islenen_q   <= islenen_d;
      karalama_q  <= karalama_d;
      sayac_q     <= sayac_d;
      isaret_ic_q <= isaret_ic_d;
      bcd_q       <= bcd_d;
      isaret_q    <= isaret_d;
      basamak_q   <= basamak_d;
      gecerli_q   <= gecerli_d;
    end
  end

  assign hazir          = (durum_q == BOSTA);
  assign mesgul         = (durum_q != BOSTA);
  assign bcd_cikis      = bcd_q;
  assign isaret         = isaret_q;
  assign basamak_sayisi = basamak_q;
  assign cikis_gecerli  = gecerli_q;

endmodule
